smoker_mode_ctrl: RTL
=====================

Name: smoker_mode_ctrl

Overview:
Wind-mode sequencer for the range-hood fan datapath. It takes single-cycle button pulses and a 1 Hz tick, and runs the mode FSM: standby, level 1, level 2, one-shot hurricane with a timed fall-back to level 2, and a delayed exit from hurricane to standby. It drives the 3-bit mode_state bus consumed by the smoker datapath, plus the countdown value for display selection.

Parameters:
HURRICANE_SEC, 60, hurricane duration in 1 Hz ticks before automatic drop to level 2
EXIT_DELAY_SEC, 60, ticks the fan stays at level 3 after menu is pressed in hurricane, before standby
CNT_W, 7, countdown width in bits; must hold max(HURRICANE_SEC, EXIT_DELAY_SEC)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
tick_1hz  input  1  one-clk-wide pulse once per second
menu_pulse  input  1  debounced menu button, one-clk pulse
mode1_pulse  input  1  debounced level-1 button, one-clk pulse
mode2_pulse  input  1  debounced level-2 button, one-clk pulse
mode3_pulse  input  1  debounced hurricane button, one-clk pulse
mode_state  output  3  fan level to datapath: 000 standby, 001 L1, 010 L2, 011 L3
countdown_sec  output  CNT_W  remaining seconds of the active countdown; 0 when none
countdown_active  output  1  high in HURRICANE and EXIT_WAIT
hurricane_used  output  1  sticky: hurricane has been entered since reset
mode_change  output  1  one-clk pulse on every change of mode_state

Behaviour:
- Reset (async, rst=1): state STANDBY; mode_state=000, countdown_sec=0, countdown_active=0, hurricane_used=0, mode_change=0. Reset mid-countdown aborts it immediately.
- All outputs are registered. A button pulse in cycle N changes state/outputs at edge N+1.
- Button priority within one cycle: menu > mode3 > mode2 > mode1. Lower-priority pulses in the same cycle are dropped.
- STANDBY (000):
  - mode1 -> L1.
  - mode2 -> L2.
  - mode3 -> HURRICANE only if hurricane_used=0; otherwise the pulse is ignored.
  - menu is ignored.
- L1 (001) / L2 (010):
  - menu -> STANDBY immediately.
  - mode1/mode2 -> L1/L2. Selecting the current level is a no-op: no mode_change pulse.
  - mode3 -> HURRICANE if hurricane_used=0, else ignored.
- HURRICANE (011):
  - On entry: countdown_sec=HURRICANE_SEC, hurricane_used=1.
  - Each tick_1hz decrements countdown_sec. A tick with countdown_sec==1 -> L2 with countdown_sec=0, giving exactly HURRICANE_SEC ticks at level 3.
  - menu -> EXIT_WAIT with countdown_sec=EXIT_DELAY_SEC.
  - mode1/2/3 are ignored.
- EXIT_WAIT (mode_state stays 011):
  - tick decrements countdown_sec. A tick at 1 -> STANDBY with countdown_sec=0.
  - All buttons are ignored.
- Same-cycle tick and accepted button: the button transition wins and loads its value. The tick is not applied to the new countdown. A tick in a non-countdown state has no effect.
- countdown_sec never underflows. In L1, L2 and STANDBY it is held at 0.
- mode_change pulses in the cycle after any edge where registered mode_state differs from its previous value. HURRICANE -> EXIT_WAIT produces no pulse.
- hurricane_used clears only on reset.

Decomposition:
- Shared package smoker_pkg holds:
  - mode codes MODE_STANDBY=3'b000, MODE_L1=3'b001, MODE_L2=3'b010, MODE_L3=3'b011;
  - FSM state enum {ST_STANDBY, ST_L1, ST_L2, ST_HURR, ST_EXIT}.
- One natural sub-module: sec_countdown.
  - Ports: load, load_val, tick, count, done_pulse.
  - done_pulse fires on the tick that takes the count from 1 to 0.
  - The FSM consumes done_pulse.

Test Plan:
1. Reset, then mode1 pulse -> mode_state=001 one cycle later, mode_change=1 for one cycle; then menu -> 000.
2. From STANDBY press mode3, apply 60 ticks -> countdown_sec goes 60..1 with mode_state=011 throughout; 60th tick -> mode_state=010, countdown_sec=0, hurricane_used=1.
3. After case 2, menu then mode3 -> mode_state stays 000 (hurricane not re-entered); mode2 -> 010.
4. Hurricane, 10 ticks (countdown_sec=50), then menu -> countdown_sec=60, mode_state stays 011, no mode_change; mode1 ignored; 60 ticks -> mode_state=000.
5. Same cycle menu+mode1+tick from L2 -> STANDBY only, countdown_sec=0; same cycle mode3+tick from STANDBY -> countdown_sec=60 (tick not applied).
6. Assert rst during EXIT_WAIT with countdown_sec=30 -> all outputs return to reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/smoker_pkg.sv
// Shared mode codes, FSM states and the state-to-fan-level mapping for the
// range-hood wind-mode sequencer.
package smoker_pkg;

   localparam logic [2:0] MODE_STANDBY = 3'b000;
   localparam logic [2:0] MODE_L1      = 3'b001;
   localparam logic [2:0] MODE_L2      = 3'b010;
   localparam logic [2:0] MODE_L3      = 3'b011;

   typedef enum logic [2:0] {
      ST_STANDBY,
      ST_L1,
      ST_L2,
      ST_HURR,
      ST_EXIT
   } state_t;

   // EXIT_WAIT keeps the fan at level 3 until its countdown runs out
   function automatic logic [2:0] mode_of(input state_t st);
      case (st)
         ST_L1:            mode_of = MODE_L1;
         ST_L2:            mode_of = MODE_L2;
         ST_HURR, ST_EXIT: mode_of = MODE_L3;
         default:          mode_of = MODE_STANDBY;
      endcase
   endfunction

endpackage

// File: rtl/smoker_mode_ctrl_if.sv
// Button/tick inputs and registered status outputs of the wind-mode sequencer.
interface smoker_mode_ctrl_if #(
   parameter int CNT_W = 7
);
   logic             tick_1hz;
   logic             menu_pulse;
   logic             mode1_pulse;
   logic             mode2_pulse;
   logic             mode3_pulse;
   logic [2:0]       mode_state;
   logic [CNT_W-1:0] countdown_sec;
   logic             countdown_active;
   logic             hurricane_used;
   logic             mode_change;

   modport master (
      output tick_1hz, menu_pulse, mode1_pulse, mode2_pulse, mode3_pulse,
      input  mode_state, countdown_sec, countdown_active, hurricane_used, mode_change
   );

   modport slave (
      input  tick_1hz, menu_pulse, mode1_pulse, mode2_pulse, mode3_pulse,
      output mode_state, countdown_sec, countdown_active, hurricane_used, mode_change
   );
endinterface

// File: rtl/sec_countdown.sv
// Loadable seconds countdown; done_pulse flags the tick that reaches zero.
module sec_countdown #(
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_tick,
   output logic [CNT_W-1:0] o_count,
   output logic             o_done_pulse
);
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            r_count <= '0;
      else if (i_load)                    r_count <= i_load_val;
      else if (i_tick && r_count != '0)   r_count <= r_count - 1'b1;
   end

   // Load precedence over a same-cycle done is resolved by the consumer
   assign o_done_pulse = i_tick && (r_count == CNT_W'(1));
   assign o_count      = r_count;

endmodule

// File: rtl/smoker_mode_ctrl.sv
// Wind-mode FSM: standby/L1/L2, one-shot timed hurricane, delayed exit to standby.
module smoker_mode_ctrl
   import smoker_pkg::*;
#(
   parameter int HURRICANE_SEC  = 60,
   parameter int EXIT_DELAY_SEC = 60,
   parameter int CNT_W          = 7
) (
   input  logic                clk,
   input  logic                rst,
   smoker_mode_ctrl_if.slave   bus
);
   state_t           r_state, w_state_nxt;
   logic [2:0]       r_mode, w_mode_nxt;
   logic             r_mode_change, r_active, r_used;
   logic             w_load, w_done, w_cnt_tick;
   logic [CNT_W-1:0] w_load_val, w_count;
   logic             w_menu, w_m3, w_m2, w_m1;

   // Only the highest-priority pulse of a cycle survives
   assign w_menu = bus.menu_pulse;
   assign w_m3   = bus.mode3_pulse && !bus.menu_pulse;
   assign w_m2   = bus.mode2_pulse && !bus.menu_pulse && !bus.mode3_pulse;
   assign w_m1   = bus.mode1_pulse && !bus.menu_pulse && !bus.mode3_pulse && !bus.mode2_pulse;

   assign w_cnt_tick = bus.tick_1hz && (r_state == ST_HURR || r_state == ST_EXIT);

   sec_countdown #(.CNT_W(CNT_W)) u_cnt (
      .clk          (clk),
      .rst          (rst),
      .i_load       (w_load),
      .i_load_val   (w_load_val),
      .i_tick       (w_cnt_tick),
      .o_count      (w_count),
      .o_done_pulse (w_done)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_val  = '0;
      case (r_state)
         ST_STANDBY, ST_L1, ST_L2: begin
            if (w_menu) begin
               w_state_nxt = ST_STANDBY;
            end else if (w_m3) begin
               if (!r_used) begin
                  w_state_nxt = ST_HURR;
                  w_load      = 1'b1;
                  w_load_val  = CNT_W'(HURRICANE_SEC);
               end
            end else if (w_m2) begin
               w_state_nxt = ST_L2;
            end else if (w_m1) begin
               w_state_nxt = ST_L1;
            end
         end
         ST_HURR: begin
            if (w_menu) begin
               w_state_nxt = ST_EXIT;
               w_load      = 1'b1;
               w_load_val  = CNT_W'(EXIT_DELAY_SEC);
            end else if (w_done) begin
               w_state_nxt = ST_L2;
            end
         end
         ST_EXIT: begin
            if (w_done) w_state_nxt = ST_STANDBY;
         end
         default: w_state_nxt = ST_STANDBY;
      endcase
   end

   assign w_mode_nxt = mode_of(w_state_nxt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_STANDBY;
         r_mode        <= MODE_STANDBY;
         r_mode_change <= 1'b0;
         r_active      <= 1'b0;
         r_used        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_mode        <= w_mode_nxt;
         r_mode_change <= (w_mode_nxt != r_mode);
         r_active      <= (w_state_nxt == ST_HURR) || (w_state_nxt == ST_EXIT);
         r_used        <= r_used || (w_state_nxt == ST_HURR);
      end
   end

   assign bus.mode_state       = r_mode;
   assign bus.countdown_sec    = w_count;
   assign bus.countdown_active = r_active;
   assign bus.hurricane_used   = r_used;
   assign bus.mode_change      = r_mode_change;

endmodule
